// File: rtl/seqdet_pkg.sv
// Shared types and defaults for the programmable serial sequence detector.
// The length-width helper keeps the cfg_len port sizing identical in every module.
package seqdet_pkg;

  localparam int DEF_MAXLEN = 8;
  localparam int DEF_CNTW   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int len_width(input int maxlen);
    return $clog2(maxlen + 1);
  endfunction

endpackage

// File: rtl/seqdet_shift_match.sv
// History shift register, fill counter and masked compare of the newest len bits.
// hit is combinational: it flags that the bit being shifted in on this edge completes a match.
module seqdet_shift_match
  import seqdet_pkg::*;
#(
  parameter int MAXLEN = DEF_MAXLEN,
  parameter int LW     = len_width(MAXLEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift,
  input  logic              clear,
  input  logic              x,
  input  logic              overlap,
  input  logic [LW-1:0]     len,
  input  logic [MAXLEN-1:0] pattern,
  output logic              hit
);

  logic [MAXLEN-1:0] r_hist;
  logic [LW-1:0]     r_fill;
  logic [MAXLEN-1:0] w_hist_next;
  logic [MAXLEN-1:0] w_mask;
  logic [LW:0]       w_fill_p1;
  logic              w_full;

  assign w_hist_next = {r_hist[MAXLEN-2:0], x};

  generate
    for (genvar gi = 0; gi < MAXLEN; gi++) begin : g_mask
      assign w_mask[gi] = (LW'(gi) < len);
    end
  endgenerate

  // One extra bit so fill+1 cannot wrap when MAXLEN+1 is a power of two.
  assign w_fill_p1 = {1'b0, r_fill} + (LW+1)'(1);
  assign w_full    = (w_fill_p1 >= {1'b0, len});
  assign hit       = shift && w_full && (((w_hist_next ^ pattern) & w_mask) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (shift) begin
      r_hist <= w_hist_next;
      if (hit && !overlap) begin
        r_fill <= '0;
      end else if (w_full) begin
        r_fill <= len;
      end else begin
        r_fill <= w_fill_p1[LW-1:0];
      end
    end
  end

endmodule

// File: rtl/seqdet_ctrl.sv
// Sequencing controller: config latch, IDLE/ARMED/DONE FSM, saturating match counter and pulses.
// busy spans ARMED and the DONE wrap-up cycle, so it falls in the cycle done pulses.
module seqdet_ctrl
  import seqdet_pkg::*;
#(
  parameter int  MAXLEN = DEF_MAXLEN,
  parameter int  CNTW   = DEF_CNTW,
  localparam int LW     = len_width(MAXLEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              x,
  input  logic              x_valid,
  input  logic              start,
  input  logic              abort,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LW-1:0]     cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNTW-1:0]   cfg_target,
  output logic              busy,
  output logic              z,
  output logic [CNTW-1:0]   match_count,
  output logic              done,
  output logic              err
);

  state_t            r_state, w_state_next;
  logic [MAXLEN-1:0] r_pattern;
  logic [LW-1:0]     r_len;
  logic              r_overlap;
  logic [CNTW-1:0]   r_target;
  logic [CNTW-1:0]   r_count, w_count_next, w_count_inc;
  logic              r_z, w_z_next;
  logic              r_done, w_done_next;
  logic              r_err, w_err_next;
  logic              w_cfg_ok, w_load, w_shift, w_hit;

  assign w_cfg_ok    = (cfg_len != '0) && (cfg_len <= LW'(MAXLEN));
  assign w_load      = (r_state == ST_IDLE) && start && w_cfg_ok;
  // Abort suppresses the shift, which also kills any simultaneous hit.
  assign w_shift     = (r_state == ST_ARMED) && x_valid && !abort;
  assign w_count_inc = (r_count == '1) ? r_count : r_count + CNTW'(1);

  seqdet_shift_match #(
    .MAXLEN (MAXLEN),
    .LW     (LW)
  ) u_shift_match (
    .clk     (clk),
    .rst     (rst),
    .shift   (w_shift),
    .clear   (w_load),
    .x       (x),
    .overlap (r_overlap),
    .len     (r_len),
    .pattern (r_pattern),
    .hit     (w_hit)
  );

  always_comb begin
    w_state_next = r_state;
    w_z_next     = 1'b0;
    w_done_next  = 1'b0;
    w_err_next   = 1'b0;
    w_count_next = r_count;
    case (r_state)
      ST_IDLE: begin
        if (start && !w_cfg_ok) begin
          w_err_next = 1'b1;
        end else if (w_load) begin
          w_count_next = '0;
          w_state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (abort) begin
          w_state_next = ST_IDLE;
        end else if (w_hit) begin
          w_z_next     = 1'b1;
          w_count_next = w_count_inc;
          if ((r_target != '0) && (w_count_inc == r_target)) begin
            w_state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_done_next  = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pattern <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_target  <= '0;
      r_count   <= '0;
      r_z       <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_z     <= w_z_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
      if (w_load) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_overlap <= cfg_overlap;
        r_target  <= cfg_target;
      end
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign z           = r_z;
  assign done        = r_done;
  assign err         = r_err;
  assign match_count = r_count;

endmodule

// File: tb/tb_seqdet_ctrl.sv
// Self-checking bench: vector table, hand-written corner sequences and randomized runs
// checked against a queue-based model of the detection rules.
module tb_seqdet_ctrl;
  localparam int MAXLEN = 8;
  localparam int CNTW   = 8;
  localparam int LW     = $clog2(MAXLEN + 1);
  localparam int CMAX   = (1 << CNTW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              x, x_valid, start, abort;
  logic [MAXLEN-1:0] cfg_pattern;
  logic [LW-1:0]     cfg_len;
  logic              cfg_overlap;
  logic [CNTW-1:0]   cfg_target;
  logic              busy, z, done, err;
  logic [CNTW-1:0]   match_count;

  always #5 clk = ~clk;

  seqdet_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
    .clk         (clk),
    .rst         (rst),
    .x           (x),
    .x_valid     (x_valid),
    .start       (start),
    .abort       (abort),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .busy        (busy),
    .z           (z),
    .match_count (match_count),
    .done        (done),
    .err         (err)
  );

  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc_n    = 0;
  string ctx      = "reset";

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s/%s cycle %0d: got %0d, expected %0d", ctx, name, cyc_n, act, exp);
  endtask

  // Reference model: keep the most recent bits since the last start (or non-overlap match).
  int m_mode;  // 0 idle, 1 armed, 2 finishing
  bit m_bits[$];
  int m_pat, m_len, m_tgt, m_cnt;
  bit m_ovl, e_z, e_done, e_err;

  function automatic void model_reset();
    m_mode = 0; m_bits.delete(); m_cnt = 0;
    m_pat = 0; m_len = 0; m_tgt = 0; m_ovl = 0;
    e_z = 0; e_done = 0; e_err = 0;
  endfunction

  function automatic int bits_value();
    int v = 0;
    foreach (m_bits[i]) v = (v << 1) | int'(m_bits[i]);
    return v;
  endfunction

  function automatic void model_step();
    e_z = 0; e_done = 0; e_err = 0;
    case (m_mode)
      0: if (start) begin
        if (cfg_len == 0 || int'(cfg_len) > MAXLEN) e_err = 1;
        else begin
          m_pat = int'(cfg_pattern); m_len = int'(cfg_len);
          m_ovl = cfg_overlap; m_tgt = int'(cfg_target);
          m_bits.delete(); m_cnt = 0; m_mode = 1;
        end
      end
      1: if (abort) m_mode = 0;
         else if (x_valid) begin
           m_bits.push_back(x);
           if (m_bits.size() > m_len) void'(m_bits.pop_front());
           if (m_bits.size() == m_len && bits_value() == (m_pat & ((1 << m_len) - 1))) begin
             e_z = 1;
             if (m_cnt < CMAX) m_cnt++;
             if (!m_ovl) m_bits.delete();
             if (m_tgt != 0 && m_cnt == m_tgt) m_mode = 2;
           end
         end
      default: begin e_done = 1; m_mode = 0; end
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    model_step();
    chk("z", int'(z), int'(e_z));
    chk("done", int'(done), int'(e_done));
    chk("err", int'(err), int'(e_err));
    chk("busy", int'(busy), int'(m_mode != 0));
    chk("count", int'(match_count), m_cnt);
  endtask

  task automatic drive(input bit st, input bit ab, input bit xv, input bit xb);
    start = st; abort = ab; x_valid = xv; x = xb;
  endtask

  task automatic cfg(input int pat, input int len, input bit ovl, input int tgt);
    cfg_pattern = MAXLEN'(pat); cfg_len = LW'(len); cfg_overlap = ovl; cfg_target = CNTW'(tgt);
  endtask

  typedef struct {
    bit st, ab, xv, xb;
    int pat, len;
    bit ovl;
    int tgt;
    bit ez, eb, ed, ee;
    int ec;
  } vec_t;

  vec_t tv[$];

  function automatic void v(bit st, bit ab, bit xv, bit xb, int pat, int len, bit ovl, int tgt,
                            bit ez, bit eb, bit ed, bit ee, int ec);
    vec_t r;
    r.st = st; r.ab = ab; r.xv = xv; r.xb = xb; r.pat = pat; r.len = len; r.ovl = ovl; r.tgt = tgt;
    r.ez = ez; r.eb = eb; r.ed = ed; r.ee = ee; r.ec = ec;
    tv.push_back(r);
  endfunction

  task automatic feed(input int bits, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      drive(0, 0, 1, bits[i]);
      cyc();
      for (int g = 0; g < gap; g++) begin
        drive(0, 0, 0, $urandom_range(0, 1));
        cyc();
      end
    end
    drive(0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0);
    cfg(0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_z", int'(z), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_count", int'(match_count), 0);
    rst = 1'b0;

    // 1011 overlap, target 0: z after bits 4 and 7.
    v(1,0,0,0, 11,4,1,0, 0,1,0,0,0);
    v(0,0,1,1, 11,4,1,0, 0,1,0,0,0); v(0,0,1,0, 11,4,1,0, 0,1,0,0,0);
    v(0,0,1,1, 11,4,1,0, 0,1,0,0,0); v(0,0,1,1, 11,4,1,0, 1,1,0,0,1);
    v(0,0,1,0, 11,4,1,0, 0,1,0,0,1); v(0,0,1,1, 11,4,1,0, 0,1,0,0,1);
    v(0,0,1,1, 11,4,1,0, 1,1,0,0,2);
    v(0,1,0,0, 11,4,1,0, 0,0,0,0,2); v(0,0,0,0, 11,4,1,0, 0,0,0,0,2);
    // Same stream without overlap: one z.
    v(1,0,0,0, 11,4,0,0, 0,1,0,0,0);
    v(0,0,1,1, 11,4,0,0, 0,1,0,0,0); v(0,0,1,0, 11,4,0,0, 0,1,0,0,0);
    v(0,0,1,1, 11,4,0,0, 0,1,0,0,0); v(0,0,1,1, 11,4,0,0, 1,1,0,0,1);
    v(0,0,1,0, 11,4,0,0, 0,1,0,0,1); v(0,0,1,1, 11,4,0,0, 0,1,0,0,1);
    v(0,0,1,1, 11,4,0,0, 0,1,0,0,1);
    v(0,1,0,0, 11,4,0,0, 0,0,0,0,1);
    // 101 target 2: done one cycle after the second z, busy drops with it.
    v(1,0,0,0, 5,3,1,2, 0,1,0,0,0);
    v(0,0,1,1, 5,3,1,2, 0,1,0,0,0); v(0,0,1,0, 5,3,1,2, 0,1,0,0,0);
    v(0,0,1,1, 5,3,1,2, 1,1,0,0,1); v(0,0,1,0, 5,3,1,2, 0,1,0,0,1);
    v(0,0,1,1, 5,3,1,2, 1,1,0,0,2);
    v(0,0,1,1, 5,3,1,2, 0,0,1,0,2); v(0,0,1,0, 5,3,1,2, 0,0,0,0,2);
    v(0,0,1,1, 5,3,1,2, 0,0,0,0,2);
    // Rejected lengths 0 and MAXLEN+1, then MAXLEN accepted.
    v(1,0,0,0, 5,0,1,0, 0,0,0,1,2); v(0,0,0,0, 5,0,1,0, 0,0,0,0,2);
    v(1,0,0,0, 5,9,1,0, 0,0,0,1,2); v(0,0,0,0, 5,9,1,0, 0,0,0,0,2);
    v(1,0,0,0, 165,8,1,0, 0,1,0,0,0); v(0,1,0,0, 165,8,1,0, 0,0,0,0,0);

    ctx = "table";
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].st, tv[i].ab, tv[i].xv, tv[i].xb);
      cfg(tv[i].pat, tv[i].len, tv[i].ovl, tv[i].tgt);
      cyc();
      chk($sformatf("row%0d_z", i), int'(z), int'(tv[i].ez));
      chk($sformatf("row%0d_busy", i), int'(busy), int'(tv[i].eb));
      chk($sformatf("row%0d_done", i), int'(done), int'(tv[i].ed));
      chk($sformatf("row%0d_err", i), int'(err), int'(tv[i].ee));
      chk($sformatf("row%0d_count", i), int'(match_count), tv[i].ec);
    end

    // Gaps of 3 invalid cycles between bits.
    ctx = "gaps";
    cfg(11, 4, 1, 0); drive(1, 0, 0, 0); cyc();
    feed(7'b1011011, 7, 3);
    chk("gap_count", int'(match_count), 2);
    drive(0, 1, 0, 0); cyc();

    // Abort on the completing edge.
    ctx = "abort";
    cfg(11, 4, 1, 0); drive(1, 0, 0, 0); cyc();
    feed(3'b101, 3, 0);
    drive(0, 1, 1, 1); cyc();
    chk("abort_z", int'(z), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_count", int'(match_count), 0);
    drive(0, 0, 0, 0); cyc();
    chk("abort_z_after", int'(z), 0);

    // Asynchronous reset in the middle of ARMED.
    ctx = "reset_mid";
    cfg(11, 4, 1, 0); drive(1, 0, 0, 0); cyc();
    feed(7'b1011011, 7, 0);
    feed(3'b101, 3, 0);
    #3 rst = 1'b1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_z", int'(z), 0);
    chk("rst_count", int'(match_count), 0);
    model_reset();
    #2 rst = 1'b0;
    feed(7'b1011011, 7, 0);
    chk("no_start_count", int'(match_count), 0);
    cfg(11, 4, 1, 0); drive(1, 0, 0, 0); cyc();
    feed(4'b1011, 4, 0);
    chk("restart_count", int'(match_count), 1);
    drive(0, 1, 0, 0); cyc();

    // Saturation of the counter with a one-bit pattern.
    ctx = "saturate";
    cfg(1, 1, 1, 0); drive(1, 0, 0, 0); cyc();
    for (int i = 0; i < CMAX + 5; i++) begin drive(0, 0, 1, 1); cyc(); end
    chk("sat_count", int'(match_count), CMAX);
    drive(0, 1, 0, 0); cyc();

    // Randomized runs against the model.
    ctx = "random";
    for (int run = 0; run < 40; run++) begin
      cfg($urandom_range(0, 255), ($urandom_range(0, 9) == 0) ? 9 * $urandom_range(0, 1)
          : $urandom_range(1, 5), $urandom_range(0, 1), $urandom_range(0, 3));
      drive(1, 0, 0, 0); cyc();
      for (int c = 0; c < 60; c++) begin
        cfg($urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 3));
        drive($urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0,
              $urandom_range(0, 9) < 7, $urandom_range(0, 1));
        cyc();
      end
      drive(0, 1, 0, 0); cyc();
      drive(0, 0, 0, 0); cyc();
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
